// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI cache-line controller: line states, bus
// operations and the controller FSM states.
package mesi_pkg;

    typedef enum logic [2:0] {
        LS_INVALID   = 3'b000,
        LS_MODIFIED  = 3'b001,
        LS_SHARED    = 3'b010,
        LS_EXCLUSIVE = 3'b011
    } line_state_e;

    typedef enum logic [1:0] {
        OP_NONE       = 2'b00,
        OP_READ_MISS  = 2'b01,
        OP_WRITE_MISS = 2'b10,
        OP_INVALIDATE = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } ctrl_state_e;

    function automatic logic line_valid(input line_state_e s);
        return (s != LS_INVALID);
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational per-line MESI transition and writeback decode, used once for
// the local CPU path and once for the snoop path.
module mesi_next_state
    import mesi_pkg::*;
(
    input  line_state_e cur_i,
    input  logic        snoop_i,
    input  bus_op_e     op_i,
    input  logic        write_i,
    input  logic        shared_i,
    output line_state_e nxt_o,
    output logic        wb_o
);

    // Snoop events demote/invalidate; CPU events upgrade on hit or fill on grant.
    always_comb begin
        nxt_o = cur_i;
        wb_o  = 1'b0;
        if (snoop_i) begin
            case (op_i)
                OP_READ_MISS: begin
                    if (cur_i == LS_MODIFIED || cur_i == LS_EXCLUSIVE) begin
                        nxt_o = LS_SHARED;
                    end else begin
                        nxt_o = cur_i;
                    end
                    wb_o = (cur_i == LS_MODIFIED);
                end
                OP_WRITE_MISS: begin
                    nxt_o = LS_INVALID;
                    wb_o  = (cur_i == LS_MODIFIED);
                end
                OP_INVALIDATE: begin
                    nxt_o = LS_INVALID;
                    wb_o  = 1'b0;
                end
                default: begin
                    nxt_o = cur_i;
                    wb_o  = 1'b0;
                end
            endcase
        end else begin
            case (op_i)
                OP_NONE: begin
                    if (write_i && (cur_i == LS_EXCLUSIVE || cur_i == LS_MODIFIED)) begin
                        nxt_o = LS_MODIFIED;
                    end else begin
                        nxt_o = cur_i;
                    end
                    wb_o = 1'b0;
                end
                OP_READ_MISS: begin
                    nxt_o = shared_i ? LS_SHARED : LS_EXCLUSIVE;
                    wb_o  = (cur_i == LS_MODIFIED);
                end
                OP_WRITE_MISS: begin
                    nxt_o = LS_MODIFIED;
                    wb_o  = (cur_i == LS_MODIFIED);
                end
                OP_INVALIDATE: begin
                    nxt_o = LS_MODIFIED;
                    wb_o  = 1'b0;
                end
                default: begin
                    nxt_o = cur_i;
                    wb_o  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// MESI coherence controller: one outstanding CPU request per time, per-line
// state tracking, bus arbitration and snoop handling every cycle.
module mesi_cache_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   cpu_valid_i,
    input  logic                   cpu_write_i,
    input  logic                   cpu_hit_i,
    input  logic [IDX_W-1:0]       cpu_idx_i,
    output logic                   cpu_ready_o,
    output logic                   bus_req_o,
    input  logic                   bus_gnt_i,
    output logic [1:0]             bus_op_o,
    output logic                   bus_wb_o,
    input  logic                   bus_shared_i,
    input  logic                   snoop_valid_i,
    input  logic                   snoop_hit_i,
    input  logic [1:0]             snoop_op_i,
    input  logic [IDX_W-1:0]       snoop_idx_i,
    output logic                   snoop_wb_o,
    output logic [3*NUM_LINES-1:0] line_state_o
);

    ctrl_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    bus_op_e          op_q, op_d;
    logic             wb_q, wb_d;
    logic             req_q, req_d;
    logic             ready_q, ready_d;
    logic             snoop_wb_q, snoop_wb_d;
    line_state_e      lines_q [NUM_LINES];
    line_state_e      lines_d [NUM_LINES];

    line_state_e      cpu_cur_s, cpu_nxt_s, snp_cur_s, snp_nxt_s;
    bus_op_e          req_op_s, cpu_op_s;
    logic             cpu_wb_s, snp_wb_s;
    logic             accept_s, grant_s, cpu_upd_s, snp_act_s;
    logic [IDX_W-1:0] cpu_upd_idx_s;

    // Request classification and CPU-path operand selection.
    always_comb begin
        accept_s      = (state_q == ST_IDLE) && cpu_valid_i;
        grant_s       = (state_q == ST_BUS) && bus_gnt_i;
        cpu_cur_s     = (state_q == ST_IDLE) ? lines_q[cpu_idx_i] : lines_q[idx_q];
        cpu_upd_idx_s = (state_q == ST_IDLE) ? cpu_idx_i : idx_q;
        req_op_s      = OP_NONE;
        if (cpu_hit_i && line_valid(cpu_cur_s)) begin
            req_op_s = (cpu_write_i && cpu_cur_s == LS_SHARED) ? OP_INVALIDATE : OP_NONE;
        end else begin
            req_op_s = cpu_write_i ? OP_WRITE_MISS : OP_READ_MISS;
        end
        cpu_op_s  = (state_q == ST_IDLE) ? req_op_s : op_q;
        cpu_upd_s = grant_s || (accept_s && req_op_s == OP_NONE);
    end

    mesi_next_state u_cpu_ns (
        .cur_i    (cpu_cur_s),
        .snoop_i  (1'b0),
        .op_i     (cpu_op_s),
        .write_i  (cpu_write_i),
        .shared_i (bus_shared_i),
        .nxt_o    (cpu_nxt_s),
        .wb_o     (cpu_wb_s)
    );

    // A snoop sees the line after a same-cycle local upgrade; a same-line grant overrides it.
    always_comb begin
        snp_cur_s = (cpu_upd_s && snoop_idx_i == cpu_upd_idx_s) ? cpu_nxt_s
                                                                : lines_q[snoop_idx_i];
        snp_act_s = snoop_valid_i && snoop_hit_i && line_valid(snp_cur_s)
                    && !(grant_s && snoop_idx_i == idx_q);
    end

    mesi_next_state u_snoop_ns (
        .cur_i    (snp_cur_s),
        .snoop_i  (1'b1),
        .op_i     (bus_op_e'(snoop_op_i)),
        .write_i  (1'b0),
        .shared_i (1'b0),
        .nxt_o    (snp_nxt_s),
        .wb_o     (snp_wb_s)
    );

    // Line-state next values and controller FSM next-state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        wb_d       = wb_q;
        req_d      = req_q;
        ready_d    = (state_q == ST_DONE);
        snoop_wb_d = snp_act_s && snp_wb_s;
        for (int i = 0; i < NUM_LINES; i++) begin
            lines_d[i] = (snp_act_s && snoop_idx_i == IDX_W'(i)) ? snp_nxt_s :
                         (cpu_upd_s && cpu_upd_idx_s == IDX_W'(i)) ? cpu_nxt_s :
                         lines_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    idx_d = cpu_idx_i;
                    if (req_op_s == OP_NONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUS;
                        op_d    = req_op_s;
                        wb_d    = cpu_wb_s;
                        req_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (grant_s) begin
                    state_d = ST_DONE;
                    op_d    = OP_NONE;
                    wb_d    = 1'b0;
                    req_d   = 1'b0;
                end else if (op_q == OP_INVALIDATE && snp_act_s && snoop_idx_i == idx_q
                             && snp_nxt_s == LS_INVALID) begin
                    // Our shared copy was lost, so the upgrade must refetch the line.
                    op_d = OP_WRITE_MISS;
                end else begin
                    op_d = op_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_NONE;
                wb_d    = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            op_q       <= OP_NONE;
            wb_q       <= 1'b0;
            req_q      <= 1'b0;
            ready_q    <= 1'b0;
            snoop_wb_q <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i] <= LS_INVALID;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            wb_q       <= wb_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
            snoop_wb_q <= snoop_wb_d;
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i] <= lines_d[i];
            end
        end
    end

    assign cpu_ready_o = ready_q;
    assign bus_req_o   = req_q;
    assign bus_op_o    = op_q;
    assign bus_wb_o    = wb_q;
    assign snoop_wb_o  = snoop_wb_q;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_pack
        assign line_state_o[3*g +: 3] = lines_q[g];
    end

endmodule
